// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter types used by the round-robin bus arbiter.
package ahb_pkg;

  localparam int MIDX_W = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic {
    ARB_PARK  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational rotating-priority selector: searches from ptr+1 upward, wrapping,
// so the master at ptr is considered last (or not at all when exclude is set).
module ahb_rr_picker
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MIDX_W-1:0]      ptr,
  input  logic                   exclude,
  output logic                   valid,
  output logic [MIDX_W-1:0]      winner
);

  logic [NUM_MASTERS-1:0] eligible;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
    assign eligible[gi] = req[gi] && !(exclude && (ptr == MIDX_W'(gi)));
  end

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (eligible[i] && (((int'(ptr) + k) % NUM_MASTERS) == i)) begin
          valid  = 1'b1;
          winner = MIDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with park master and hready-qualified hand-over.
// Optional owner tenure limit compiled in with AHB_ARB_TENURE_LIMIT_EN.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [1:0]             hmaster,
  output logic [1:0]             hmaster_data
);

  localparam logic [MIDX_W-1:0]      DEF_IDX   = MIDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e             state_q, state_d;
  logic [MIDX_W-1:0]      owner_q, owner_d;
  logic [MIDX_W-1:0]      data_q, data_d;
  logic [MIDX_W-1:0]      ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;

  logic              owner_req;
  logic              retry_split;
  logic              pick_exclude;
  logic              pick_valid;
  logic [MIDX_W-1:0] pick_idx;
  logic              force_handover;

  assign owner_req   = |(hbusreq & grant_q);
  assign retry_split = (hresp == HRESP_RETRY) || (hresp == HRESP_SPLIT);

  ahb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req    (hbusreq),
    .ptr    (ptr_q),
    .exclude(pick_exclude),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef AHB_ARB_TENURE_LIMIT_EN
  localparam int                TEN_W   = $clog2(MAX_TENURE + 1);
  localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

  logic [TEN_W-1:0] tenure_q, tenure_d, tenure_inc;
  logic             tenure_expired;

  assign tenure_inc     = (tenure_q == TEN_MAX) ? tenure_q : tenure_q + TEN_W'(1);
  assign tenure_expired = (state_q == ARB_OWNED) && (tenure_inc == TEN_MAX);
  // A RETRY/SPLIT re-arbitration must still be able to regrant a sole owner.
  assign pick_exclude   = tenure_expired && !retry_split;
  assign force_handover = pick_exclude && owner_req && pick_valid && (htrans != HTRANS_SEQ);

  always_comb begin
    tenure_d = tenure_q;
    if (hready) begin
      if ((state_q != ARB_OWNED) || (state_d != ARB_OWNED) || (owner_d != owner_q)) begin
        tenure_d = '0;
      end else begin
        tenure_d = tenure_inc;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      tenure_q <= '0;
    end else begin
      tenure_q <= tenure_d;
    end
  end
`else
  logic unused_tenure_inputs;
  assign unused_tenure_inputs = ^{htrans, (MAX_TENURE > 0)};
  assign pick_exclude         = 1'b0;
  assign force_handover       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (hready) begin
      data_d = owner_q;
      if (state_q == ARB_PARK) begin
        if (pick_valid) begin
          state_d = ARB_OWNED;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
        end
      end else if (retry_split || !owner_req || force_handover) begin
        if (pick_valid) begin
          owner_d = pick_idx;
          ptr_d   = pick_idx;
        end else begin
          // Parking keeps the pointer on the last real owner.
          state_d = ARB_PARK;
          owner_d = DEF_IDX;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
    assign grant_d[gi] = (owner_d == MIDX_W'(gi));
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ARB_PARK;
      owner_q <= DEF_IDX;
      data_q  <= DEF_IDX;
      ptr_q   <= DEF_IDX;
      grant_q <= DEF_GRANT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign hgrant       = grant_q;
  assign hmaster      = owner_q;
  assign hmaster_data = data_q;

endmodule
